// File: rtl/buzzer.sv
// Square-wave tone generator for the panel buzzer.
// A one-hot select picks one of four notes; the half-period counts come from CLOCK_FREQ.
module buzzer #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned FREQ_0     = 262,
    parameter int unsigned FREQ_1     = 330,
    parameter int unsigned FREQ_2     = 392,
    parameter int unsigned FREQ_3     = 523
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       conta,
    input  logic [3:0] seletor,
    output logic       pulso
);

    function automatic int unsigned half_period(input int unsigned freq);
        int unsigned h;
        if (freq == 0) begin
            return 1;
        end
        h = CLOCK_FREQ / (2 * freq);
        return (h < 1) ? 1 : h;
    endfunction

    localparam int unsigned HALF_0 = half_period(FREQ_0);
    localparam int unsigned HALF_1 = half_period(FREQ_1);
    localparam int unsigned HALF_2 = half_period(FREQ_2);
    localparam int unsigned HALF_3 = half_period(FREQ_3);

    localparam int unsigned MAX_01   = (HALF_0 > HALF_1) ? HALF_0 : HALF_1;
    localparam int unsigned MAX_23   = (HALF_2 > HALF_3) ? HALF_2 : HALF_3;
    localparam int unsigned MAX_HALF = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;

    localparam int unsigned CNT_W_RAW = $clog2(MAX_HALF) + 1;
    localparam int unsigned CNT_W     = (CNT_W_RAW < 2) ? 2 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] LAST_0 = CNT_W'(HALF_0 - 1);
    localparam logic [CNT_W-1:0] LAST_1 = CNT_W'(HALF_1 - 1);
    localparam logic [CNT_W-1:0] LAST_2 = CNT_W'(HALF_2 - 1);
    localparam logic [CNT_W-1:0] LAST_3 = CNT_W'(HALF_3 - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pulso;
    logic [3:0]       r_sel;

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_pulso_next;
    logic [CNT_W-1:0] w_last;
    logic             w_onehot;

    assign w_onehot = (seletor != 4'b0000) && ((seletor & (seletor - 4'd1)) == 4'b0000);

    always_comb begin
        w_last = '0;
        case (seletor)
            4'b0001: w_last = LAST_0;
            4'b0010: w_last = LAST_1;
            4'b0100: w_last = LAST_2;
            4'b1000: w_last = LAST_3;
            default: w_last = '0;
        endcase
    end

    always_comb begin
        w_cnt_next   = r_cnt;
        w_pulso_next = r_pulso;
        if (!conta || !w_onehot) begin
            w_cnt_next   = '0;
            w_pulso_next = 1'b0;
        end else if (seletor != r_sel) begin
            // New note: restart phase-aligned, low half first.
            w_cnt_next   = '0;
            w_pulso_next = 1'b0;
        end else if (r_cnt == w_last) begin
            w_cnt_next   = '0;
            w_pulso_next = ~r_pulso;
        end else if (r_cnt > w_last) begin
            w_cnt_next   = '0;
        end else begin
            w_cnt_next   = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_pulso <= 1'b0;
            r_sel   <= 4'b0000;
        end else begin
            r_cnt   <= w_cnt_next;
            r_pulso <= w_pulso_next;
            r_sel   <= seletor;
        end
    end

    assign pulso = r_pulso;

endmodule

// File: tb/tb_buzzer.sv
// Self-checking bench for buzzer at CLOCK_FREQ=5000, compared against a run-length tone model.
module tb_buzzer;

    localparam int unsigned CF = 5000;

    logic       clock;
    logic       reset;
    logic       conta;
    logic [3:0] seletor;
    logic       pulso;

    int errors;
    int checks;

    // Model: edges since the current tone run began, previous select, expected output.
    int unsigned m_run;
    logic [3:0]  m_prev;
    logic        m_pulso;

    buzzer #(
        .CLOCK_FREQ(CF),
        .FREQ_0    (262),
        .FREQ_1    (330),
        .FREQ_2    (392),
        .FREQ_3    (523)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .conta  (conta),
        .seletor(seletor),
        .pulso  (pulso)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int unsigned calc_half(input int unsigned f);
        int unsigned h;
        h = CF / (2 * f);
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int unsigned m_half(input logic [3:0] s);
        case (s)
            4'b0001: return calc_half(262);
            4'b0010: return calc_half(330);
            4'b0100: return calc_half(392);
            default: return calc_half(523);
        endcase
    endfunction

    task automatic model_reset();
        m_run   = 0;
        m_prev  = 4'b0000;
        m_pulso = 1'b0;
    endtask

    // Advance one rising edge, update the model, then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else begin
            if (!conta || $countones(seletor) != 1 || seletor != m_prev) begin
                m_run   = 0;
                m_pulso = 1'b0;
            end else begin
                m_run   = m_run + 1;
                m_pulso = ((m_run / m_half(seletor)) % 2) == 1;
            end
            m_prev = seletor;
        end
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        conta   = 1'b1;
        seletor = 4'b1000;
        model_reset();
        tick();
        checks++;
        if (pulso !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulso: got %b want 0", pulso);
        end
        checks++;
        if (dut.r_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counter: got %0d want 0", dut.r_cnt);
        end
        reset = 1'b1;
        begin
            int first_rise;
            first_rise = -1;
            for (int i = 1; i <= 10; i++) begin
                tick();
                checks++;
                if (pulso !== m_pulso) begin
                    errors++;
                    $display("FAIL reset_release_model cyc %0d: got %b want %b", i, pulso, m_pulso);
                end
                if (pulso === 1'b1 && first_rise < 0) first_rise = i;
            end
            checks++;
            if (first_rise != 5) begin
                errors++;
                $display("FAIL reset_first_rise: got edge %0d want edge 5", first_rise);
            end
        end
    endtask

    task automatic test_tone3();
        logic prev;
        int   last_toggle;
        last_toggle = -1;
        prev = pulso;
        for (int i = 1; i <= 50; i++) begin
            tick();
            checks++;
            if (pulso !== m_pulso) begin
                errors++;
                $display("FAIL tone3_model cyc %0d: got %b want %b", i, pulso, m_pulso);
            end
            if (pulso !== prev) begin
                if (last_toggle >= 0) begin
                    checks++;
                    if (i - last_toggle != 4) begin
                        errors++;
                        $display("FAIL tone3_half: got %0d want 4", i - last_toggle);
                    end
                end
                last_toggle = i;
            end
            prev = pulso;
        end
    endtask

    task automatic test_switch();
        logic [3:0] sels [3];
        int         exph [3];
        sels[0] = 4'b0001; exph[0] = 9;
        sels[1] = 4'b0100; exph[1] = 6;
        sels[2] = 4'b0010; exph[2] = 7;
        for (int t = 0; t < 3; t++) begin
            logic prev;
            int   last_toggle;
            last_toggle = -1;
            seletor = sels[t];
            tick();
            checks++;
            if (pulso !== 1'b0) begin
                errors++;
                $display("FAIL switch_restart sel %b: got %b want 0", sels[t], pulso);
            end
            prev = pulso;
            for (int i = 2; i <= 50; i++) begin
                tick();
                checks++;
                if (pulso !== m_pulso) begin
                    errors++;
                    $display("FAIL switch_model sel %b cyc %0d: got %b want %b",
                             sels[t], i, pulso, m_pulso);
                end
                if (pulso !== prev) begin
                    checks++;
                    if (last_toggle < 0) begin
                        if (i != exph[t] + 1) begin
                            errors++;
                            $display("FAIL switch_first_rise sel %b: got edge %0d want edge %0d",
                                     sels[t], i, exph[t] + 1);
                        end
                    end else if (i - last_toggle != exph[t]) begin
                        errors++;
                        $display("FAIL switch_half sel %b: got %0d want %0d",
                                 sels[t], i - last_toggle, exph[t]);
                    end
                    last_toggle = i;
                end
                prev = pulso;
            end
        end
    endtask

    task automatic wait_high(input string name);
        int n;
        n = 0;
        while (pulso !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (pulso !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_wait_high: got %b want 1 within 40 edges", name, pulso);
        end
    endtask

    task automatic test_disable();
        conta   = 1'b1;
        seletor = 4'b1000;
        wait_high("disable");
        conta = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (pulso !== 1'b0) begin
                errors++;
                $display("FAIL disable_low cyc %0d: got %b want 0", i, pulso);
            end
        end
        conta = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (pulso !== m_pulso) begin
                errors++;
                $display("FAIL reenable_model cyc %0d: got %b want %b", i, pulso, m_pulso);
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (pulso !== (i == 4)) begin
                    errors++;
                    $display("FAIL reenable_phase cyc %0d: got %b want %b", i, pulso, i == 4);
                end
            end
        end
    endtask

    task automatic test_invalid();
        logic [3:0] bad [2];
        bad[0] = 4'b0000;
        bad[1] = 4'b0110;
        conta = 1'b1;
        for (int b = 0; b < 2; b++) begin
            seletor = bad[b];
            for (int i = 1; i <= 20; i++) begin
                tick();
                checks++;
                if (pulso !== 1'b0) begin
                    errors++;
                    $display("FAIL invalid_low sel %b cyc %0d: got %b want 0", bad[b], i, pulso);
                end
            end
        end
        seletor = 4'b0001;
        begin
            int first_rise;
            first_rise = -1;
            for (int i = 1; i <= 30; i++) begin
                tick();
                checks++;
                if (pulso !== m_pulso) begin
                    errors++;
                    $display("FAIL invalid_resume_model cyc %0d: got %b want %b", i, pulso, m_pulso);
                end
                if (pulso === 1'b1 && first_rise < 0) first_rise = i;
            end
            checks++;
            if (first_rise != 10) begin
                errors++;
                $display("FAIL invalid_resume_rise: got edge %0d want edge 10", first_rise);
            end
        end
    endtask

    task automatic test_async_reset();
        conta   = 1'b1;
        seletor = 4'b0100;
        wait_high("async");
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pulso !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b want 0", pulso);
        end
        tick();
        checks++;
        if (pulso !== 1'b0 || dut.r_cnt !== '0) begin
            errors++;
            $display("FAIL async_reset_hold: got pulso %b cnt %0d want 0/0", pulso, dut.r_cnt);
        end
        #2;
        reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (pulso !== m_pulso) begin
                errors++;
                $display("FAIL async_release_model cyc %0d: got %b want %b", i, pulso, m_pulso);
            end
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 40; seg++) begin
            int unsigned r;
            int unsigned hold;
            r = $urandom_range(0, 9);
            if (r < 8) seletor = 4'b0001 << (r % 4);
            else if (r == 8) seletor = 4'b0000;
            else seletor = 4'($urandom_range(0, 15));
            conta = ($urandom_range(0, 7) != 0);
            hold  = $urandom_range(1, 25);
            for (int i = 0; i < int'(hold); i++) begin
                tick();
                checks++;
                if (pulso !== m_pulso) begin
                    errors++;
                    $display("FAIL random_model seg %0d sel %b conta %b: got %b want %b",
                             seg, seletor, conta, pulso, m_pulso);
                end
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset   = 1'b0;
        conta   = 1'b0;
        seletor = 4'b0000;
        model_reset();
        test_reset();
        test_tone3();
        test_switch();
        test_disable();
        test_invalid();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buzzer.md
Name: buzzer

Overview:
- Tone generator for the panel buzzer.
- A one-hot `seletor` picks one of four note frequencies. While `conta` is high, `pulso` carries a 50%-duty square wave at that frequency.
- The divider is derived from the CLOCK_FREQ parameter, so simulation can use a slow clock (for example 5 kHz).

Parameters:
- CLOCK_FREQ, 50_000_000, input clock frequency in Hz.
- FREQ_0, 262, tone in Hz for seletor = 4'b0001.
- FREQ_1, 330, tone in Hz for seletor = 4'b0010.
- FREQ_2, 392, tone in Hz for seletor = 4'b0100.
- FREQ_3, 523, tone in Hz for seletor = 4'b1000.

Ports:
- clock  input  1  system clock; the single clock, all state on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- conta  input  1  enable; 1 = generate tone, 0 = silent.
- seletor  input  4  one-hot tone select.
- pulso  output  1  square-wave buzzer drive, registered.

Behaviour:
- Half-period constants are computed at elaboration with integer division (truncate): HALF_i = CLOCK_FREQ / (2*FREQ_i).
  - A result below 1 is forced to 1.
  - With CLOCK_FREQ=5000: HALF_0=9, HALF_1=7, HALF_2=6, HALF_3=4.
- Counter width is ceil(log2(max HALF_i)) + 1 bits, minimum 2.
- Reset (reset=0, asynchronous): counter = 0, pulso = 0, stored select = 0. Takes effect immediately, including mid-tone.
- Valid select means seletor has exactly one bit set. HALF is the constant belonging to that bit.
- On each rising clock edge, the first matching rule applies:
  1. conta=0 or seletor not one-hot (zero or multiple bits set): counter <= 0, pulso <= 0. Silent, with no partial toggles.
  2. seletor differs from the value registered on the previous edge: counter <= 0, pulso <= 0. The new tone restarts phase-aligned, low first.
  3. counter == HALF-1: counter <= 0, pulso <= ~pulso.
  4. Otherwise: counter <= counter + 1.
- The stored select register samples seletor on every edge, independent of conta.
- Resulting waveform:
  - After enabling with a stable valid select, pulso stays 0 for HALF cycles, then toggles every HALF cycles.
  - Period is 2*HALF clock cycles, duty cycle exactly 50%.
- Latency:
  - First rising edge of pulso occurs HALF clock edges after the first edge on which conta=1 and seletor is valid and stable.
  - A select change costs one extra edge for the restart.
- Dropping conta forces pulso low on the next edge. Re-raising conta restarts from phase 0.
- The counter never exceeds HALF-1, so no wrap-around states are reachable. An unreachable counter value resets to 0.
- pulso comes directly from a flop; the output is glitch-free.

Test Plan:
- Reset: hold reset=0 for 1 cycle with conta=1, seletor=4'b1000 -> pulso=0 and counter=0 during reset. After release, the first pulso rise comes 4 edges after the select is registered.
- Tone 3 (CLOCK_FREQ=5000): conta=1, seletor=4'b1000 for 50 cycles -> pulso toggles every 4 cycles, period 8 cycles (625 Hz effective), duty 4/8.
- Tone switch: change seletor to 4'b0001, then 4'b0100, then 4'b0010, 50 cycles each -> pulso restarts low at each change, then runs at half-periods of 9, 6 and 7 cycles respectively.
- Disable: conta=0 mid-tone while pulso=1 -> pulso=0 on the next edge and stays 0. Re-enable -> pulso stays low for the full first half-period.
- Invalid select: seletor=4'b0000, then 4'b0110, with conta=1 -> pulso held 0. Return to 4'b0001 -> normal 9-cycle half-period resumes from phase 0.
- Asynchronous reset mid-tone: assert reset=0 between clock edges while pulso=1 -> pulso drops to 0 immediately, without waiting for a clock edge.
